// File: rtl/spi_target.sv
// ============================================================================
// Module   : spi_target
// Brief    : SPI target (slave) engine. Synchronizes SCK/CSn/SDI into clk,
//            runs the bit-level shift protocol in all four SCK modes and
//            exchanges frames with local logic through TX/RX FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_target #(
  parameter int FIFODEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCKIn,
  input  logic       CSnIn,
  input  logic       SDIIn,
  output logic       SDOut,
  output logic       SDOutEn,
  input  logic [1:0] SckMode,
  input  logic [3:0] Len,
  input  logic       LsbFirst,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  output logic       TxUnderrun,
  output logic       RxOverrun
);

  localparam int              c_aw      = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(FIFODEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // synchronizers and edge-detect copy
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_csn_s1, r_csn_s2;
  logic r_sdi_s1, r_sdi_s2;

  // protocol state
  state_t     r_state;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [3:0] r_cnt;
  logic       r_sdoen;
  logic       r_underrun;
  logic       r_overrun;

  // FIFO storage
  logic [7:0]      r_tx_mem [FIFODEPTH];
  logic [c_aw-1:0] r_tx_wr, r_tx_rd;
  logic [c_aw:0]   r_tx_cnt;
  logic [7:0]      r_rx_mem [FIFODEPTH];
  logic [c_aw-1:0] r_rx_wr, r_rx_rd;
  logic [c_aw:0]   r_rx_cnt;

  logic       w_sck_rise, w_sck_fall, w_lead, w_trail;
  logic       w_sample_edge, w_shift_edge;
  logic [3:0] w_len;
  logic [2:0] w_msb_idx;
  logic [7:0] w_mask;
  logic [7:0] w_rx_next;
  logic [3:0] w_cnt_inc;
  logic       w_start, w_act, w_sample, w_shift, w_done, w_load;
  logic       w_tx_empty, w_tx_push, w_tx_pop;
  logic       w_rx_full, w_rx_push, w_rx_pop;
  logic [7:0] w_tx_load_val;

  // Two-flop synchronizers; idle levels are CSn deasserted and SCK low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_csn_s1 <= 1'b1;
      r_csn_s2 <= 1'b1;
      r_sdi_s1 <= 1'b0;
      r_sdi_s2 <= 1'b0;
    end else begin
      r_sck_s1 <= SCKIn;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_csn_s1 <= CSnIn;
      r_csn_s2 <= r_csn_s1;
      r_sdi_s1 <= SDIIn;
      r_sdi_s2 <= r_sdi_s1;
    end
  end

  assign w_sck_rise    = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall    = ~r_sck_s2 & r_sck_d;
  assign w_lead        = SckMode[1] ? w_sck_fall : w_sck_rise;
  assign w_trail       = SckMode[1] ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = SckMode[0] ? w_trail : w_lead;
  assign w_shift_edge  = SckMode[0] ? w_lead : w_trail;

  // Out-of-range lengths (0, >8) behave as full bytes
  assign w_len     = ((Len == 4'd0) || (Len > 4'd8)) ? 4'd8 : Len;
  assign w_msb_idx = 3'(w_len - 4'd1);
  assign w_mask    = 8'hFF >> (4'd8 - w_len);
  assign w_cnt_inc = r_cnt + 4'd1;

  // Next RX shift value: MSB first enters at bit 0, LSB first at bit Len-1
  always_comb begin
    w_rx_next = {r_rx_sr[6:0], r_sdi_s2};
    if (LsbFirst) begin
      w_rx_next            = r_rx_sr >> 1;
      w_rx_next[w_msb_idx] = r_sdi_s2;
    end
  end

  assign w_start  = (r_state == ST_IDLE) && !r_csn_s2;
  assign w_act    = (r_state == ST_ACTIVE) && !r_csn_s2;
  assign w_sample = w_act && w_sample_edge;
  assign w_shift  = w_act && w_shift_edge && (r_cnt != 4'd0);
  assign w_done   = w_sample && (w_cnt_inc == w_len);
  assign w_load   = w_start || w_done;

  assign w_tx_empty    = (r_tx_cnt == '0);
  assign TxReady       = (r_tx_cnt != c_depth);
  assign w_tx_push     = TxValid && TxReady;
  assign w_tx_pop      = w_load && !w_tx_empty;
  assign w_tx_load_val = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

  assign w_rx_full = (r_rx_cnt == c_depth);
  assign RxValid   = (r_rx_cnt != '0);
  assign w_rx_push = w_done && !w_rx_full;
  assign w_rx_pop  = RxValid && RxReady;
  assign RxData    = RxValid ? r_rx_mem[r_rx_rd] : 8'h00;

  assign SDOut      = r_sdoen & (LsbFirst ? r_tx_sr[0] : r_tx_sr[w_msb_idx]);
  assign SDOutEn    = r_sdoen;
  assign TxUnderrun = r_underrun;
  assign RxOverrun  = r_overrun;

  // Frame FSM: select/deselect, sample/shift, frame completion and reload
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx_sr    <= 8'h00;
      r_rx_sr    <= 8'h00;
      r_cnt      <= 4'd0;
      r_sdoen    <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= w_load && w_tx_empty;
      r_overrun  <= w_done && w_rx_full;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_ACTIVE;
            r_tx_sr <= w_tx_load_val;
            r_rx_sr <= 8'h00;
            r_cnt   <= 4'd0;
            r_sdoen <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (r_csn_s2) begin
            // deselect aborts any partial frame
            r_state <= ST_IDLE;
            r_tx_sr <= 8'h00;
            r_rx_sr <= 8'h00;
            r_cnt   <= 4'd0;
            r_sdoen <= 1'b0;
          end else if (w_done) begin
            r_tx_sr <= w_tx_load_val;
            r_rx_sr <= 8'h00;
            r_cnt   <= 4'd0;
          end else if (w_sample) begin
            r_rx_sr <= w_rx_next;
            r_cnt   <= w_cnt_inc;
          end else if (w_shift) begin
            r_tx_sr <= LsbFirst ? (r_tx_sr >> 1) : (r_tx_sr << 1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // TX FIFO pointers and occupancy; pop on every frame load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_ptr_one;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_ptr_one;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_cnt_one;
        2'b01:   r_tx_cnt <= r_tx_cnt - c_cnt_one;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= TxData;
  end

  // RX FIFO pointers and occupancy; full FIFO drops completed frames
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_ptr_one;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_ptr_one;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_cnt_one;
        2'b01:   r_rx_cnt <= r_rx_cnt - c_cnt_one;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // RX FIFO storage, masked to the active frame length
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_next & w_mask;
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
// ============================================================================
// Module   : tb_spi_target
// Brief    : Self-checking bench for spi_target: directed vector table,
//            hand-written corner sequences and randomized sessions checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_target;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCKIn, CSnIn, SDIIn;
  logic       SDOut, SDOutEn;
  logic [1:0] SckMode;
  logic [3:0] Len;
  logic       LsbFirst;
  logic [7:0] TxData;
  logic       TxValid, TxReady;
  logic [7:0] RxData;
  logic       RxValid, RxReady;
  logic       TxUnderrun, RxOverrun;

  spi_target #(.FIFODEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .SCKIn(SCKIn), .CSnIn(CSnIn), .SDIIn(SDIIn),
    .SDOut(SDOut), .SDOutEn(SDOutEn), .SckMode(SckMode), .Len(Len),
    .LsbFirst(LsbFirst), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .TxUnderrun(TxUnderrun), .RxOverrun(RxOverrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_und = 0, n_ovr = 0;
  int exp_und = 0, exp_ovr = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur;

  // pulse counters
  always @(posedge clk) begin
    if (TxUnderrun) n_und <= n_und + 1;
    if (RxOverrun)  n_ovr <= n_ovr + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] mode;
    int         len;
    logic       lsb;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 8) ? 8 : l;
  endfunction

  function automatic logic [7:0] lmask(input int l);
    return 8'((1 << eff_len(l)) - 1);
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: frame load takes TX head or 0 with an underrun
  function automatic logic [7:0] model_load();
    if (tx_q.size() > 0) return tx_q.pop_front();
    exp_und++;
    return 8'h00;
  endfunction

  task automatic setup(input logic [1:0] mode, input int len, input logic lsb);
    SckMode  = mode;
    Len      = 4'(len);
    LsbFirst = lsb;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int g = 0;
    while (!TxReady && g < 100) begin wclk(1); g++; end
    if (g == 100) check("tx_ready_wait", 0, 1);
    TxData  = d;
    TxValid = 1'b1;
    wclk(1);
    TxValid = 1'b0;
    tx_q.push_back(d);
  endtask

  task automatic cs_begin(input logic [1:0] mode);
    SCKIn = mode[1];
    wclk(6);
    CSnIn = 1'b0;
    wclk(6);
    cur = model_load();
  endtask

  task automatic cs_end();
    wclk(3);
    CSnIn = 1'b1;
    wclk(6);
  endtask

  // SPI master: nbits bits, 6-clk SCK phases, samples SDOut at its sample edge
  task automatic spi_bits(input logic [1:0] mode, input int len, input logic lsb,
                          input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    int el = eff_len(len);
    int bi;
    logic rb;
    miso = 8'h00;
    rb   = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bi    = lsb ? i : (el - 1 - i);
      SDIIn = mosi[bi];
      wclk(3);
      if (!mode[0]) rb = SDOut;
      SCKIn = ~mode[1];
      wclk(6);
      if (mode[0]) rb = SDOut;
      SCKIn = mode[1];
      wclk(3);
      miso[bi] = rb;
    end
  endtask

  // full frame plus model update: expected MISO and RX push/overrun
  task automatic do_frame(input logic [1:0] mode, input int len, input logic lsb,
                          input logic [7:0] mosi, output logic [7:0] got, output logic [7:0] expd);
    spi_bits(mode, len, lsb, mosi, eff_len(len), got);
    expd = cur & lmask(len);
    if (rx_q.size() < DEPTH) rx_q.push_back(mosi & lmask(len));
    else exp_ovr++;
    cur = model_load();
  endtask

  task automatic drain(input string tag);
    while (rx_q.size() > 0) begin
      check({tag, "_rxvalid"}, RxValid, 1);
      check({tag, "_rxdata"}, RxData, rx_q.pop_front());
      RxReady = 1'b1;
      wclk(1);
      RxReady = 1'b0;
    end
    check({tag, "_rxempty"}, RxValid, 0);
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_underruns"}, n_und, exp_und);
    check({tag, "_overruns"}, n_ovr, exp_ovr);
  endtask

  initial begin
    logic [7:0] got, expd, got2, expd2;
    int nf, np;
    logic [1:0] m;
    int l;
    logic b;

    vecs[0] = '{2'd0, 8,  1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{2'd3, 8,  1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[2] = '{2'd2, 4,  1'b0, 8'h1E, 8'h05, 8'h0E, 8'h05};
    vecs[3] = '{2'd1, 0,  1'b1, 8'h6C, 8'hC3, 8'h6C, 8'hC3};
    vecs[4] = '{2'd0, 12, 1'b0, 8'hF0, 8'h01, 8'hF0, 8'h01};
    vecs[5] = '{2'd3, 3,  1'b1, 8'hFD, 8'h06, 8'h05, 8'h06};

    reset = 1'b1; SCKIn = 1'b0; CSnIn = 1'b1; SDIIn = 1'b0;
    SckMode = 2'd0; Len = 4'd8; LsbFirst = 1'b0;
    TxData = 8'h00; TxValid = 1'b0; RxReady = 1'b0;
    wclk(4);
    reset = 1'b0;
    wclk(1);
    check("rst_sdout", SDOut, 0);
    check("rst_sdouten", SDOutEn, 0);
    check("rst_txready", TxReady, 1);
    check("rst_rxvalid", RxValid, 0);
    check("rst_rxdata", RxData, 0);
    check("rst_pulses", {30'd0, TxUnderrun, RxOverrun}, 0);

    // directed table: one frame per selection, spare TX entry covers the reload
    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].mode, vecs[i].len, vecs[i].lsb);
      push_tx(vecs[i].tx);
      push_tx(8'h00);
      cs_begin(vecs[i].mode);
      check("tbl_sdouten", SDOutEn, 1);
      do_frame(vecs[i].mode, vecs[i].len, vecs[i].lsb, vecs[i].mosi, got, expd);
      cs_end();
      check("tbl_miso", got, vecs[i].exp_miso);
      check("tbl_rxvalid", RxValid, 1);
      check("tbl_rxdata", RxData, vecs[i].exp_rx);
      RxReady = 1'b1; wclk(1); RxReady = 1'b0;
      void'(rx_q.pop_front());
      check("tbl_rxempty", RxValid, 0);
      check("tbl_sdouten_off", SDOutEn, 0);
      check_pulses("tbl");
    end

    // mode 1, Len 5, two back-to-back frames under one selection
    setup(2'd1, 5, 1'b0);
    push_tx(8'h1B);
    push_tx(8'h04);
    cs_begin(2'd1);
    do_frame(2'd1, 5, 1'b0, 8'h11, got, expd);
    do_frame(2'd1, 5, 1'b0, 8'h1F, got2, expd2);
    cs_end();
    check("b2b_miso0", got, 8'h1B);
    check("b2b_miso1", got2, 8'h04);
    check("b2b_rx0", RxData, 8'h11);
    drain("b2b");
    check_pulses("b2b");

    // TX FIFO empty at selection: underrun and zero data, RX still captured
    setup(2'd0, 8, 1'b0);
    cs_begin(2'd0);
    do_frame(2'd0, 8, 1'b0, 8'hE7, got, expd);
    cs_end();
    check("und_miso", got, 8'h00);
    check("und_rx", RxData, 8'hE7);
    drain("und");
    check_pulses("und");

    // RX overrun: fill FIFO, one more frame 0x77 must be dropped
    setup(2'd0, 8, 1'b0);
    cs_begin(2'd0);
    for (int i = 0; i < DEPTH; i++) do_frame(2'd0, 8, 1'b0, 8'(i + 1), got, expd);
    check("ovr_pre_pulses", n_ovr, exp_ovr);
    do_frame(2'd0, 8, 1'b0, 8'h77, got, expd);
    cs_end();
    check("ovr_head", RxData, 8'h01);
    drain("ovr");
    check_pulses("ovr");

    // mode 2 abort after 3 bits, then a clean frame after reselect
    setup(2'd2, 8, 1'b0);
    push_tx(8'h5A);
    push_tx(8'hC3);
    cs_begin(2'd2);
    spi_bits(2'd2, 8, 1'b0, 8'hFF, 3, got);
    cs_end();
    check("abort_sdouten", SDOutEn, 0);
    check("abort_sdout", SDOut, 0);
    check("abort_rxvalid", RxValid, 0);
    cs_begin(2'd2);
    do_frame(2'd2, 8, 1'b0, 8'h96, got, expd);
    cs_end();
    check("abort_next_miso", got, 8'hC3);
    check("abort_next_rx", RxData, 8'h96);
    drain("abort");
    check_pulses("abort");

    // TX FIFO full deasserts TxReady
    for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
    check("tx_full_ready", TxReady, 0);

    // randomized sessions against the queue model
    for (int s = 0; s < 24; s++) begin
      m = 2'($urandom_range(0, 3));
      l = $urandom_range(0, 15);
      b = 1'($urandom_range(0, 1));
      setup(m, l, b);
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) if (tx_q.size() < DEPTH) push_tx(8'($urandom));
      nf = $urandom_range(1, 3);
      cs_begin(m);
      for (int f = 0; f < nf; f++) begin
        do_frame(m, l, b, 8'($urandom), got, expd);
        check("rnd_miso", got, expd);
      end
      cs_end();
      drain("rnd");
      check_pulses("rnd");
    end

    // reset in the middle of a frame
    setup(2'd0, 8, 1'b0);
    push_tx(8'h3A);
    cs_begin(2'd0);
    spi_bits(2'd0, 8, 1'b0, 8'hAA, 4, got);
    reset = 1'b1;
    wclk(1);
    reset = 1'b0;
    check("mrst_sdouten", SDOutEn, 0);
    check("mrst_txready", TxReady, 1);
    check("mrst_rxvalid", RxValid, 0);
    check("mrst_rxdata", RxData, 0);
    CSnIn = 1'b1;
    wclk(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_target.md
# spi_target

SPI target (slave) engine: the responder end of the SPI link driven by the SoC's SPI controller, for attaching a Wally-side device to an external SPI master or for loopback-verifying the controller. Synchronizes the incoming SCK/CS/SDI pins into `clk`, runs the bit-level shift protocol in all four SCK modes, and exchanges frames with local logic through depth-parameterized TX and RX FIFOs with valid/ready handshakes. Sits between the pad ring and a future memory-mapped wrapper.

## Interface
- `FIFODEPTH`, 8, entries per TX and RX FIFO; power of two, ≥2.
- `clk`  in  1  system clock; single clock domain. This block has one clock.
- `reset`  in  1  synchronous, active-high reset.
- `SCKIn`  in  1  SPI clock from master (asynchronous).
- `CSnIn`  in  1  chip select from master, active low (asynchronous).
- `SDIIn`  in  1  master-out data (asynchronous).
- `SDOut`  out  1  target-out data.
- `SDOutEn`  out  1  output enable for the SDOut pad; 1 only while selected.
- `SckMode`  in  2  {CPOL, CPHA}; static while CS is asserted.
- `Len`  in  4  frame length in bits, 1–8; 0 and values >8 mean 8.
- `LsbFirst`  in  1  0 = MSB first, 1 = LSB first.
- `TxData`  in  8  frame to send; right-justified, bits above `Len` ignored.
- `TxValid`  in  1  / `TxReady`  out  1  TX FIFO push handshake.
- `RxData`  out  8  received frame, right-justified, upper bits 0.
- `RxValid`  out  1  / `RxReady`  in  1  RX FIFO pop handshake; `RxData` = FIFO head.
- `TxUnderrun`  out  1  one-cycle pulse: frame load found TX FIFO empty.
- `RxOverrun`  out  1  one-cycle pulse: completed frame dropped, RX FIFO full.

## Operation
- Pin sync: two flops each on SCK, CSn, SDI; edges detected by comparing synchronized SCK with a third registered copy. Only synchronized values are used internally.
- Leading edge = SCK leaving the CPOL idle level; trailing edge = return to it. CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- State: IDLE (CSn high) and ACTIVE (CSn low). IDLE→ACTIVE on synchronized CSn falling: load TX shift register from FIFO head (pop) or 0x00 if empty (pulse `TxUnderrun`), bit counter := 0, `SDOutEn` := 1.
- `SDOut` = next outgoing bit of TX shift register (bit `Len`-1 for MSB first, bit 0 for LSB first).
- Shift edge: if bit counter = 0, no shift (first bit already presented); otherwise advance TX shift register one bit.
- Sample edge: shift synchronized SDI into RX shift register (MSB first: into bit 0 shifting left; LSB first: into bit `Len`-1 shifting right), counter +1.
- Frame completion (sample making counter = `Len`): push assembled frame to RX FIFO; if full, drop it and pulse `RxOverrun` (FIFO content unchanged). Same cycle: reload TX shift register from FIFO (or 0x00 + `TxUnderrun`), counter := 0. Back-to-back frames need no CS toggle.
- ACTIVE→IDLE on synchronized CSn rising, any counter value: partial RX frame discarded (no push, no pulse), counter := 0, `SDOutEn` := 0, `SDOut` := 0. The TX entry already popped for the aborted frame is lost.
- FIFOs: standard circular buffers with occupancy count; `TxReady` = not full; `RxValid` = not empty. Simultaneous push and pop on a full RX FIFO or empty TX FIFO are not passed through: full RX rejects push even with `RxReady`; empty TX load yields 0x00 even with `TxValid` that cycle.
- SCK edges while IDLE are ignored.

## Timing
- Reset values: `SDOut` 0, `SDOutEn` 0, `TxReady` 1, `RxValid` 0, `RxData` 0, `TxUnderrun` 0, `RxOverrun` 0; FIFOs empty, state IDLE, sync flops set to CSn=1, SCK=0.
- Pin-to-internal latency: 2 cycles sync + 1 cycle edge detect; `SDOut` updates on the clock after the detected edge (3 cycles after the pin edge).
- SCK high and low phases must each be ≥4 `clk` periods; CS setup to first SCK edge ≥4 periods.
- RX FIFO push visible (`RxValid` high) the cycle after frame completion. TX push accepted on clock when `TxValid & TxReady`.
- `reset` mid-frame returns everything to reset values within one cycle; FIFO contents cleared.

## Test plan
- Mode 0, Len 8, MSB first: TX 0xA5 queued, master sends 0x3C -> master receives 0xA5, `RxData`=0x3C with `RxValid` after 8th sample, no pulses.
- Mode 3, LSB first, Len 8: TX 0x81, master sends 0x0F -> master sees bits 1,0,0,0,0,0,0,1; `RxData`=0x0F.
- Mode 1, Len 5: TX 0x1B then 0x04 queued, two back-to-back frames sending 0x11, 0x1F, one CS assertion -> master gets 0x1B, 0x04; RX FIFO holds 0x11, 0x1F.
- TX FIFO empty at CS fall -> `TxUnderrun` pulse, master receives 0x00; RX still captured.
- RX FIFO filled to `FIFODEPTH` with `RxReady`=0, one more frame 0x77 -> `RxOverrun` pulse, FIFO head and count unchanged, 0x77 absent.
- CS deasserted after 3 bits of mode 2 frame -> no RX push, `SDOutEn` 0; next full frame after reselect received correctly.
